// File: rtl/uart_rx_debug_pkg.sv
// Shared definitions for the debug-unit UART receiver: state encoding, default
// frame/baud parameters and the debug command byte values.
package uart_rx_debug_pkg;

    localparam int unsigned DEF_DBIT     = 8;
    localparam int unsigned DEF_SB_TICK  = 16;
    localparam int unsigned DEF_BAUD_DIV = 163;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Command bytes understood by the pipeline debug unit
    localparam logic [7:0] CMD_C_LO = 8'h63;
    localparam logic [7:0] CMD_C_UP = 8'h43;
    localparam logic [7:0] CMD_S_LO = 8'h73;
    localparam logic [7:0] CMD_S_UP = 8'h53;
    localparam logic [7:0] CMD_R_LO = 8'h72;
    localparam logic [7:0] CMD_R_UP = 8'h52;

endpackage

// File: rtl/uart_rx_debug_baud_tick_gen.sv
// Free-running oversampling tick generator: one-cycle s_tick_c every BAUD_DIV
// clocks. Shared with the matching transmitter.
module uart_rx_debug_baud_tick_gen
    import uart_rx_debug_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic top_clk,
    input  logic top_rst,
    output logic s_tick_c
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge top_clk or posedge top_rst) begin
        if (top_rst)          cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 16'd1;
    end

    assign s_tick_c = (cnt == LAST);

endmodule

// File: rtl/uart_rx_debug.sv
// 16x-oversampled UART receiver (8N1, LSB first) feeding the debug unit.
// Optional even-parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_debug
    import uart_rx_debug_pkg::*;
#(
    parameter int unsigned DBIT     = DEF_DBIT,
    parameter int unsigned SB_TICK  = DEF_SB_TICK,
    parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic            top_clk,
    input  logic            top_rst,
    input  logic            rx,
    output logic            rx_done_tick,
    output logic [DBIT-1:0] rx_bus,
    output logic            rx_frame_err,
    output logic            rx_parity_err
);

    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] BIT_LAST  = 4'd15;
    localparam logic [3:0] STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

    rx_state_t       state, state_n;
    logic            rx_meta, rx_s;
    logic            s_tick;
    logic [3:0]      s_cnt, s_cnt_n;
    logic [2:0]      n_cnt, n_cnt_n;
    logic [DBIT-1:0] b, b_n;
    logic            done_n, ferr_n;
    logic            par_bad, par_bad_n, perr_n;

    uart_rx_debug_baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .top_clk  (top_clk),
        .top_rst  (top_rst),
        .s_tick_c (s_tick)
    );

    // Two-flop synchroniser; the line idles high
    always_ff @(posedge top_clk or posedge top_rst) begin
        if (top_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge top_clk or posedge top_rst) begin
        if (top_rst) begin
            state        <= IDLE;
            s_cnt        <= '0;
            n_cnt        <= '0;
            b            <= '0;
            par_bad      <= 1'b0;
            rx_done_tick <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_bus       <= '0;
        end else begin
            state        <= state_n;
            s_cnt        <= s_cnt_n;
            n_cnt        <= n_cnt_n;
            b            <= b_n;
            par_bad      <= par_bad_n;
            rx_done_tick <= done_n;
            rx_frame_err <= ferr_n;
            if (done_n) rx_bus <= b;
        end
    end

    always_comb begin
        state_n   = state;
        s_cnt_n   = s_cnt;
        n_cnt_n   = n_cnt;
        b_n       = b;
        par_bad_n = par_bad;
        done_n    = 1'b0;
        ferr_n    = 1'b0;
        perr_n    = 1'b0;
        case (state)
            IDLE: begin
                par_bad_n = 1'b0;
                if (!rx_s) begin
                    state_n = START;
                    s_cnt_n = '0;
                end
            end
            START: if (s_tick) begin
                if (s_cnt == MID_START) begin
                    if (!rx_s) begin
                        state_n = DATA;
                        s_cnt_n = '0;
                        n_cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    s_cnt_n = s_cnt + 4'd1;
                end
            end
            DATA: if (s_tick) begin
                if (s_cnt == BIT_LAST) begin
                    b_n     = {rx_s, b[DBIT-1:1]};
                    s_cnt_n = '0;
                    if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        n_cnt_n = n_cnt + 3'd1;
                    end
                end else begin
                    s_cnt_n = s_cnt + 4'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit hold an even number of ones
            PARITY: if (s_tick) begin
                if (s_cnt == BIT_LAST) begin
                    par_bad_n = (^b) ^ rx_s;
                    s_cnt_n   = '0;
                    state_n   = STOP;
                end else begin
                    s_cnt_n = s_cnt + 4'd1;
                end
            end
`endif
            STOP: if (s_tick) begin
                if (s_cnt == STOP_LAST) begin
                    done_n  = rx_s & ~par_bad;
                    ferr_n  = ~rx_s;
                    perr_n  = par_bad;
                    state_n = IDLE;
                end else begin
                    s_cnt_n = s_cnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge top_clk or posedge top_rst) begin
        if (top_rst) rx_parity_err <= 1'b0;
        else         rx_parity_err <= perr_n;
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
